// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions for the memory responder and its byte RAM.
//   WB_DATA_W / WB_ADDR_W / WB_SEL_W : bus field widths
//   wb_resp_state_t                  : responder FSM states
//   wb_sel_mask()                    : expand byte selects to a bit mask
package wishbone_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT,
    WB_RESP
  } wb_resp_state_t;

  // Byte lane n selects data bits [8n+7:8n].
  function automatic logic [WB_DATA_W-1:0] wb_sel_mask(input logic [WB_SEL_W-1:0] sel);
    logic [WB_DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(WB_SEL_W); i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_byte_ram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read.
// Contents are not reset.
//   clk_i    : clock, rising edge
//   en_i     : access enable (read or write this edge)
//   we_i     : 1 = write selected lanes, 0 = read into rdata_o
//   sel_i    : byte lane write enables
//   addr_i   : word index
//   wdata_i  : write data
//   rdata_o  : registered read data, updated only on read accesses
module wb_byte_ram
  import wishbone_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [WB_SEL_W-1:0]      sel_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WB_DATA_W-1:0]     wdata_i,
  output logic [WB_DATA_W-1:0]     rdata_o
);

  logic [WB_DATA_W-1:0] mem_q [DEPTH];
  logic [WB_DATA_W-1:0] rdata_q;
  logic [WB_DATA_W-1:0] wmask;

  always_comb begin
    wmask = wb_sel_mask(sel_i);
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= (mem_q[addr_i] & ~wmask) | (wdata_i & wmask);
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wishbone_mem_responder.sv
// Wishbone classic-cycle responder backed by a word-addressed memory.
// Accepts one request at a time, inserts WAIT_STATES cycles, then terminates
// with a one-cycle ack (in window) or err (out of window). Dropping cyc/stb
// before the response edge aborts the transfer with no termination and no write.
//   clk_i    : clock, rising edge
//   rstn_i   : asynchronous active-low reset
//   wb_dat_i : write data          wb_adr_i : byte address
//   wb_sel_i : byte lane selects   wb_we_i  : 1 = write
//   wb_cyc_i : cycle active        wb_stb_i : transfer strobe
//   wb_dat_o : read data while wb_ack_o on a read, else 0
//   wb_ack_o : normal termination pulse
//   wb_err_o : error termination pulse
module wishbone_mem_responder
  import wishbone_pkg::*;
#(
  parameter int unsigned   DEPTH       = 32,
  parameter logic [31:0]   BASE_ADDR   = 32'h0,
  parameter int unsigned   WAIT_STATES = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  input  logic [WB_ADDR_W-1:0] wb_adr_i,
  input  logic [WB_SEL_W-1:0]  wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Window bounds carried at 33 bits so a window ending at 4 GiB cannot wrap.
  localparam logic [WB_ADDR_W:0] WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [WB_ADDR_W:0] WIN_SPAN = {1'b0, 32'(DEPTH * 4)};
  localparam logic [WB_ADDR_W:0] WIN_HI   = WIN_LO + WIN_SPAN;

  // Counter value on the last WAIT cycle.
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  wb_resp_state_t       state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WB_DATA_W-1:0] dat_q, dat_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic                 we_q, we_d;
  logic                 hit_q, hit_d;

  logic                 req;
  logic                 adr_hit;
  logic [IDX_W-1:0]     adr_idx;
  logic                 resp_live;
  logic                 ram_en;
  logic                 ram_we;
  logic [IDX_W-1:0]     ram_addr;
  logic [WB_DATA_W-1:0] ram_rdata;

  assign req     = wb_cyc_i & wb_stb_i;
  assign adr_hit = ({1'b0, wb_adr_i} >= WIN_LO) && ({1'b0, wb_adr_i} < WIN_HI);
  assign adr_idx = wb_adr_i[IDX_W+1:2];

  // Next-state logic and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    hit_d   = hit_q;
    unique case (state_q)
      WB_IDLE: begin
        if (req) begin
          idx_d   = adr_idx;
          dat_d   = wb_dat_i;
          sel_d   = wb_sel_i;
          we_d    = wb_we_i;
          hit_d   = adr_hit;
          cnt_d   = '0;
          state_d = (WAIT_STATES == 0) ? WB_RESP : WB_WAIT;
        end
      end
      WB_WAIT: begin
        if (!req) begin
          state_d = WB_IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = WB_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WB_RESP: begin
        state_d = WB_IDLE;
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= WB_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
    end
  end

  // The termination is only live while the master still holds cyc/stb, so a
  // drop during RESP suppresses both the pulse and the write on that edge.
  assign resp_live = (state_q == WB_RESP) && req;

  // Reads are issued on the edge entering RESP; writes on the edge leaving it.
  // In IDLE the request has not been latched yet, so address the RAM directly.
  always_comb begin
    ram_we   = resp_live && hit_q && we_q;
    ram_en   = ram_we || ((state_q != WB_RESP) && (state_d == WB_RESP) && !we_d);
    ram_addr = (state_q == WB_IDLE) ? adr_idx : idx_q;
  end

  wb_byte_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .sel_i   (sel_q),
    .addr_i  (ram_addr),
    .wdata_i (dat_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wb_ack_o = resp_live && hit_q;
    wb_err_o = resp_live && !hit_q;
    wb_dat_o = (wb_ack_o && !we_q) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_wishbone_mem_responder.sv
// Directed bench for wishbone_mem_responder. Three instances cover
// WAIT_STATES = 1, 3 and 0 (index 0, 1, 2), all DEPTH=32, BASE_ADDR=0.
module tb_wishbone_mem_responder;
  import wishbone_pkg::*;

  logic        clk;
  logic        rstn;
  logic [31:0] wdat [3];
  logic [31:0] adr  [3];
  logic [3:0]  sel  [3];
  logic        we   [3];
  logic        cyc  [3];
  logic        stb  [3];
  logic [31:0] rdat [3];
  logic        ack  [3];
  logic        err  [3];

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wishbone_mem_responder #(.DEPTH(32), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut_ws1 (
    .clk_i(clk), .rstn_i(rstn), .wb_dat_i(wdat[0]), .wb_adr_i(adr[0]), .wb_sel_i(sel[0]),
    .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_dat_o(rdat[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0])
  );

  wishbone_mem_responder #(.DEPTH(32), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut_ws3 (
    .clk_i(clk), .rstn_i(rstn), .wb_dat_i(wdat[1]), .wb_adr_i(adr[1]), .wb_sel_i(sel[1]),
    .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_dat_o(rdat[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1])
  );

  wishbone_mem_responder #(.DEPTH(32), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_ws0 (
    .clk_i(clk), .rstn_i(rstn), .wb_dat_i(wdat[2]), .wb_adr_i(adr[2]), .wb_sel_i(sel[2]),
    .wb_we_i(we[2]), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_dat_o(rdat[2]),
    .wb_ack_o(ack[2]), .wb_err_o(err[2])
  );

  task automatic drive(input int d, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sl);
    cyc[d]  = c;
    stb[d]  = s;
    we[d]   = w;
    adr[d]  = a;
    wdat[d] = wd;
    sel[d]  = sl;
  endtask

  // One complete transfer: measures latency, termination kind, read data and pulse width.
  task automatic xfer(input string name, input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] sl, input int exp_lat,
                      input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    drive(d, 1'b1, 1'b1, w, a, wd, sl);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (ack[d] || err[d]) lat = k;
    end
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d (0 = none)", name, lat, exp_lat);
    end
    if (lat != 0) begin
      vectors++;
      if (ack[d] !== !exp_err || err[d] !== exp_err) begin
        miscompares++;
        $display("FAIL %s termination: got ack=%0b err=%0b expected ack=%0b err=%0b",
                 name, ack[d], err[d], !exp_err, exp_err);
      end
      if (chk_rd) begin
        vectors++;
        if (rdat[d] !== exp_rd) begin
          miscompares++;
          $display("FAIL %s read data: got %h expected %h", name, rdat[d], exp_rd);
        end
      end
    end
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    vectors++;
    if (ack[d] !== 1'b0 || err[d] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pulse width: got ack=%0b err=%0b expected both 0", name, ack[d], err[d]);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdat[d] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset outputs[%0d]: got ack=%0b err=%0b dat=%h expected 0/0/0",
                 d, ack[d], err[d], rdat[d]);
      end
    end
    vectors++;
    if (dut_ws1.state_q !== WB_IDLE || dut_ws3.state_q !== WB_IDLE ||
        dut_ws0.state_q !== WB_IDLE) begin
      miscompares++;
      $display("FAIL reset state: got %0d/%0d/%0d expected all IDLE",
               dut_ws1.state_q, dut_ws3.state_q, dut_ws0.state_q);
    end
    rstn = 1'b1;
  endtask

  task automatic test_write_read();
    xfer("wr 08", 0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 2, 1'b0, 1'b0, 32'h0);
    xfer("rd 08", 0, 1'b0, 32'h08, 32'h0, 4'hF, 2, 1'b0, 1'b1, 32'hDEADBEEF);
  endtask

  task automatic test_byte_select();
    xfer("wr b0", 0, 1'b1, 32'h08, 32'h000000AA, 4'b0001, 2, 1'b0, 1'b0, 32'h0);
    xfer("wr b2", 0, 1'b1, 32'h08, 32'h00BB0000, 4'b0100, 2, 1'b0, 1'b0, 32'h0);
    xfer("wr sel0", 0, 1'b1, 32'h08, 32'h12345678, 4'b0000, 2, 1'b0, 1'b0, 32'h0);
    xfer("rd merged", 0, 1'b0, 32'h08, 32'h0, 4'hF, 2, 1'b0, 1'b1, 32'hDEBBBEAA);
  endtask

  task automatic test_out_of_range();
    xfer("wr 00", 0, 1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 2, 1'b0, 1'b0, 32'h0);
    // 0x80 aliases word 0 in its index bits but lies outside the window.
    xfer("wr 80", 0, 1'b1, 32'h80, 32'h11111111, 4'hF, 2, 1'b1, 1'b0, 32'h0);
    xfer("rd 80", 0, 1'b0, 32'h80, 32'h0, 4'hF, 2, 1'b1, 1'b1, 32'h0);
    xfer("rd 00", 0, 1'b0, 32'h00, 32'h0, 4'hF, 2, 1'b0, 1'b1, 32'hCAFEF00D);
    xfer("rd 7c", 0, 1'b0, 32'h7C, 32'h0, 4'hF, 2, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_abort();
    xfer("ws3 wr 04", 1, 1'b1, 32'h04, 32'hA5A5A5A5, 4'hF, 4, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 32'h04, 32'h12345678, 4'hF);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      vectors++;
      if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL abort cycle %0d: got ack=%0b err=%0b expected both 0", k, ack[1], err[1]);
      end
    end
    xfer("ws3 rd 04", 1, 1'b0, 32'h04, 32'h0, 4'hF, 4, 1'b0, 1'b1, 32'hA5A5A5A5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat [4];
    int          idx;
    pat[0] = 32'h01020304;
    pat[1] = 32'hF0E0D0C0;
    pat[2] = 32'h5A5A0000;
    pat[3] = 32'h0000A5A5;
    for (int i = 0; i < 4; i++) begin
      xfer("ws0 wr", 2, 1'b1, 32'(i * 4), pat[i], 4'hF, 1, 1'b0, 1'b0, 32'h0);
    end
    idx = 0;
    @(posedge clk); #1;
    drive(2, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (ack[2] !== (k % 2 == 1) || err[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b cycle %0d: got ack=%0b err=%0b expected ack=%0b err=0",
                 k, ack[2], err[2], (k % 2 == 1));
      end
      if (ack[2] === 1'b1 && idx < 4) begin
        vectors++;
        if (rdat[2] !== pat[idx]) begin
          miscompares++;
          $display("FAIL b2b data %0d: got %h expected %h", idx, rdat[2], pat[idx]);
        end
        idx++;
        if (idx < 4) adr[2] = 32'(idx * 4);
      end
    end
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    vectors++;
    if (idx != 4) begin
      miscompares++;
      $display("FAIL b2b ack count: got %0d expected 4", idx);
    end
  endtask

  task automatic test_reset_mid();
    xfer("ws3 wr 0c", 1, 1'b1, 32'h0C, 32'h0BADC0DE, 4'hF, 4, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h55555555, 4'hF);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if (dut_ws3.state_q !== WB_IDLE) begin
      miscompares++;
      $display("FAIL rst mid state: got %0d expected %0d", dut_ws3.state_q, WB_IDLE);
    end
    vectors++;
    if (ack[1] !== 1'b0 || err[1] !== 1'b0 || rdat[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL rst mid outputs: got ack=%0b err=%0b dat=%h expected 0/0/0",
               ack[1], err[1], rdat[1]);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst held: got ack=%0b err=%0b expected both 0", ack[1], err[1]);
    end
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2 rstn = 1'b1;
    xfer("ws3 rd 0c", 1, 1'b0, 32'h0C, 32'h0, 4'hF, 4, 1'b0, 1'b1, 32'h0BADC0DE);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_write_read();
    test_byte_select();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
